reaction_controller: RTL
========================

REACTION_CONTROLLER -- requirements
Module: reaction_controller

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100000000, system clock frequency; ms tick divisor TICK_DIV = CLK_FREQ_HZ/1000.
REQ-002 SHALL have parameter MIN_DELAY_MS, default 1000, minimum random wait in ms.
REQ-003 SHALL have parameter RAND_BITS, default 11, LFSR bits added to the wait (0..2^RAND_BITS-1 ms).
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  debounced single-cycle start pulse.
REQ-007 SHALL have port stop  input  1  debounced single-cycle reaction pulse.
REQ-008 SHALL have port show_best  input  1  level; selects the best time in DONE (BEST_TIME_EN only).
REQ-009 SHALL have ports thousand, hund, ten, unit  output  4 each  BCD digits for the 4-digit display driver.
REQ-010 SHALL have port led_stimulus  output  1  high while the reaction is being timed.
REQ-011 SHALL have port busy  output  1  high in WAIT or COUNT.
REQ-012 SHALL have port timeout  output  1  high in DONE when the count saturated.

Function
REQ-013 SHALL implement states IDLE, WAIT, COUNT, DONE, EARLY.
REQ-014 IDLE/DONE/EARLY + start -> WAIT; load delay_ms = MIN_DELAY_MS + lfsr[RAND_BITS-1:0]; clear BCD count to 0000.
REQ-015 WAIT: decrement delay_ms per ms tick; tick that takes it to 0 -> COUNT next cycle.
REQ-016 WAIT + stop -> EARLY next cycle; stop wins over a coincident final tick.
REQ-017 COUNT: BCD count +1 per ms tick, ripple carry unit->ten->hund->thousand, each digit 0..9.
REQ-018 COUNT + stop -> DONE next cycle; digits frozen at the pre-edge value; a tick coincident with stop is not counted.
REQ-019 COUNT: increment from 9999 -> saturate 9999, -> DONE with timeout=1.
REQ-020 Ms-tick counter SHALL clear on entry to WAIT and COUNT; first tick exactly TICK_DIV cycles after entry.
REQ-021 start ignored in WAIT and COUNT; stop ignored in IDLE, DONE, EARLY.
REQ-022 Digits: IDLE/WAIT 0000; COUNT live count; DONE frozen result; EARLY all 4'hA (dash code).
REQ-023 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every clock in all states.
REQ-024 All outputs registered; led_stimulus=1 exactly in COUNT; timeout cleared on leaving DONE.

Reset
REQ-025 On reset: state IDLE, digits 0000, led_stimulus/busy/timeout 0, tick counter 0, delay_ms 0, LFSR 16'hACE1.
REQ-026 Reset in any state incl. mid-WAIT/COUNT SHALL take effect on the same edge and override start/stop.

Configuration
REQ-027 Macro REACTION_BEST_TIME_EN defined: keep best register (reset 9999); on each non-timeout DONE entry, best = min(best, result).
REQ-028 With macro: DONE + show_best=1 -> digits show best; show_best=0 -> last result.
REQ-029 Without macro: no best register; show_best ignored; DONE always shows last result.

Structure
REQ-030 Package reaction_pkg SHALL hold the state enum, EARLY_CODE 4'hA, LFSR_SEED 16'hACE1, BCD_MAX 9999.
REQ-031 The 4-digit saturating BCD counter SHALL be sub-module bcd_counter4 (clear, inc, sat flag, four digit outputs).

Verification (CLK_FREQ_HZ=4000 -> TICK_DIV=4; MIN_DELAY_MS=2; RAND_BITS=2)
REQ-032 Reset, then start -> busy=1, WAIT; COUNT after (2+lfsr[1:0])*4 cycles; led_stimulus=1.
REQ-033 In COUNT, stop after 37 ticks -> DONE, digits 0,0,3,7, led_stimulus=0, timeout=0.
REQ-034 stop during WAIT -> EARLY, digits A,A,A,A, busy=0; start -> WAIT, digits 0000.
REQ-035 No stop for 10000 ticks -> DONE, digits 9,9,9,9, timeout=1.
REQ-036 With REACTION_BEST_TIME_EN, results 0120 then 0085 then 0200, show_best=1 -> 0,0,8,5.
REQ-037 reset asserted mid-COUNT with stop on the same cycle -> IDLE, digits 0000, all flags 0 next cycle.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time controller.
// Holds the FSM state enum, display codes, the LFSR seed/step and BCD helpers.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_COUNT,
        ST_DONE,
        ST_EARLY
    } state_t;

    localparam logic [3:0]  EARLY_CODE = 4'hA;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam int          BCD_MAX    = 9999;

    function automatic logic [15:0] to_bcd16(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    localparam logic [15:0] BCD_MAX_DIGITS = to_bcd16(BCD_MAX);

    // Fibonacci LFSR with taps 16,14,13,11 in right-shift form.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit saturating BCD counter with synchronous clear.
// o_next exposes the value the digits will hold after the next edge.
module bcd_counter4
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_inc,
    output logic        o_sat,
    output logic [3:0]  o_thousand,
    output logic [3:0]  o_hund,
    output logic [3:0]  o_ten,
    output logic [3:0]  o_unit,
    output logic [15:0] o_next
);

    logic [15:0] r_bcd;
    logic [3:0]  w_carry;
    logic [15:0] w_inc_val;

    assign o_sat      = (r_bcd == BCD_MAX_DIGITS);
    assign w_carry[0] = i_inc & ~o_sat;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] w_d;
            logic       w_nine;
            assign w_d    = r_bcd[4*gi +: 4];
            assign w_nine = (w_d == 4'd9);
            assign w_inc_val[4*gi +: 4] = w_carry[gi] ? (w_nine ? 4'd0 : w_d + 4'd1) : w_d;
            if (gi < 3) begin : g_ripple
                assign w_carry[gi+1] = w_carry[gi] & w_nine;
            end
        end
    endgenerate

    assign o_next = i_clear ? 16'h0000 : w_inc_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd <= 16'h0000;
        end else begin
            r_bcd <= o_next;
        end
    end

    assign o_thousand = r_bcd[15:12];
    assign o_hund     = r_bcd[11:8];
    assign o_ten      = r_bcd[7:4];
    assign o_unit     = r_bcd[3:0];

endmodule

// File: rtl/reaction_controller.sv
// Reaction-time game controller: random wait, ms reaction timer, BCD display outputs.
// Optional best-time memory is enabled by defining REACTION_BEST_TIME_EN.
module reaction_controller
    import reaction_pkg::*;
#(
    parameter int CLK_FREQ_HZ  = 100000000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       show_best,
    output logic [3:0] thousand,
    output logic [3:0] hund,
    output logic [3:0] ten,
    output logic [3:0] unit,
    output logic       led_stimulus,
    output logic       busy,
    output logic       timeout
);

    localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DLY_W    = $clog2(MIN_DELAY_MS + (1 << RAND_BITS)) + 1;

    state_t             r_state;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic [DLY_W-1:0]   r_delay_ms;
    logic [15:0]        r_lfsr;
    logic [15:0]        r_disp;
    logic               r_led;
    logic               r_busy;
    logic               r_timeout;

    logic               w_tick;
    logic               w_idle_like;
    logic               w_clear;
    logic               w_inc;
    logic               w_sat;
    logic [3:0]         w_c_thousand, w_c_hund, w_c_ten, w_c_unit;
    logic [15:0]        w_cnt_cur;
    logic [15:0]        w_cnt_next;
    logic [15:0]        w_done_disp;

    assign w_tick      = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_EARLY);
    assign w_clear     = w_idle_like && start;
    // A tick coinciding with stop is dropped so the frozen result is the pre-edge count.
    assign w_inc       = (r_state == ST_COUNT) && w_tick && !stop;
    assign w_cnt_cur   = {w_c_thousand, w_c_hund, w_c_ten, w_c_unit};

    bcd_counter4 u_count (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clear),
        .i_inc      (w_inc),
        .o_sat      (w_sat),
        .o_thousand (w_c_thousand),
        .o_hund     (w_c_hund),
        .o_ten      (w_c_ten),
        .o_unit     (w_c_unit),
        .o_next     (w_cnt_next)
    );

`ifdef REACTION_BEST_TIME_EN
    logic [15:0] r_best;
    logic [15:0] w_best_cand;
    logic [15:0] w_done_best;
    logic        w_stop_hit;

    // Packed BCD orders the same as its decimal value, so a plain compare works.
    assign w_stop_hit  = (r_state == ST_COUNT) && stop;
    assign w_best_cand = (w_cnt_cur < r_best) ? w_cnt_cur : r_best;
    assign w_done_best = w_stop_hit ? w_best_cand : r_best;
    assign w_done_disp = show_best ? w_done_best : w_cnt_cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_best <= BCD_MAX_DIGITS;
        end else if (w_stop_hit) begin
            r_best <= w_best_cand;
        end
    end
`else
    logic w_unused_show_best;
    assign w_unused_show_best = show_best;
    assign w_done_disp        = w_cnt_cur;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_tick_cnt <= '0;
            r_delay_ms <= '0;
            r_lfsr     <= LFSR_SEED;
            r_disp     <= 16'h0000;
            r_led      <= 1'b0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_lfsr     <= lfsr_next(r_lfsr);
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
            case (r_state)
                ST_IDLE, ST_DONE, ST_EARLY: begin
                    if (start) begin
                        r_state    <= ST_WAIT;
                        r_delay_ms <= DLY_W'(MIN_DELAY_MS) + DLY_W'(r_lfsr[RAND_BITS-1:0]);
                        r_tick_cnt <= '0;
                        r_disp     <= 16'h0000;
                        r_busy     <= 1'b1;
                        r_timeout  <= 1'b0;
                    end else if (r_state == ST_DONE) begin
                        r_disp <= w_done_disp;
                    end
                end
                ST_WAIT: begin
                    if (stop) begin
                        r_state <= ST_EARLY;
                        r_busy  <= 1'b0;
                        r_disp  <= {4{EARLY_CODE}};
                    end else if (w_tick) begin
                        if (r_delay_ms <= DLY_W'(1)) begin
                            r_state    <= ST_COUNT;
                            r_delay_ms <= '0;
                            r_tick_cnt <= '0;
                            r_led      <= 1'b1;
                        end else begin
                            r_delay_ms <= r_delay_ms - DLY_W'(1);
                        end
                    end
                end
                ST_COUNT: begin
                    if (stop || (w_tick && w_sat)) begin
                        r_state   <= ST_DONE;
                        r_led     <= 1'b0;
                        r_busy    <= 1'b0;
                        r_timeout <= !stop;
                        r_disp    <= w_done_disp;
                    end else begin
                        r_disp <= w_cnt_next;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign thousand     = r_disp[15:12];
    assign hund         = r_disp[11:8];
    assign ten          = r_disp[7:4];
    assign unit         = r_disp[3:0];
    assign led_stimulus = r_led;
    assign busy         = r_busy;
    assign timeout      = r_timeout;

endmodule
